arb_client_bank: RTL and testbench
==================================

ARB_CLIENT_BANK -- requirements
Module: arb_client_bank

Interface
REQ-001 Parameter HOLD_CYC, default 4: cycles a client holds the bus once granted (range 1..255).
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum cycles a client waits for grant (range 2..255).
REQ-003 Parameter MAX_PEND, default 3: maximum queued jobs per client (range 1..7).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  [3:1]  per-client one-cycle pulse; enqueues one job.
REQ-007 g  input  [3:1]  grant from the 3-way priority arbiter; at most one bit set.
REQ-008 r  output  [3:1]  request to the arbiter.
REQ-009 busy  output  [3:1]  client currently holds grant.
REQ-010 done  output  [3:1]  one-cycle pulse, job completed.
REQ-011 tmo  output  [3:1]  one-cycle pulse, job dropped on grant timeout.
REQ-012 ovf  output  [3:1]  one-cycle pulse, start rejected because queue full.
REQ-013 lost  output  [3:1]  one-cycle pulse, grant withdrawn during hold.

Function
REQ-014 Three identical, independent client channels n=1..3 shall exist; channel n drives r[n], busy[n], done[n], tmo[n], ovf[n], lost[n] and samples start[n], g[n].
REQ-015 Each channel shall keep a pending counter pend (0..MAX_PEND): +1 on start, -1 on done or tmo; both in same cycle leaves it unchanged.
REQ-016 start when pend==MAX_PEND with no same-cycle decrement shall leave pend unchanged and pulse ovf the next cycle.
REQ-017 Channel FSM states: IDLE, REQ, HOLD, REL.
REQ-018 IDLE: r=0; pend>0 -> REQ next cycle, wait counter cleared.
REQ-019 REQ: r=1; g[n]=1 -> HOLD with hold counter loaded HOLD_CYC-1; else wait counter increments; wait counter == TIMEOUT_CYC-1 with g[n]=0 -> REL, tmo pulse, pend decrement.
REQ-020 HOLD: r=1, busy=1; hold counter decrements each cycle; counter==0 -> REL, done pulse, pend decrement.
REQ-021 HOLD with g[n]=0 shall -> REL, pulse lost, keep job queued (pend unchanged), no done.
REQ-022 REL: r=0 for exactly one cycle, then IDLE; this guarantees the arbiter returns to its idle state between jobs.
REQ-023 g[n] in IDLE or REL shall be ignored.
REQ-024 done, tmo, lost shall be registered, asserted in the cycle the FSM is in REL; ovf registered one cycle after the rejected start.
REQ-025 busy shall be asserted for exactly HOLD_CYC cycles per uninterrupted grant.

Reset
REQ-026 reset sampled high shall force all channels to IDLE, pend=0, all counters 0, all outputs 0 the following cycle.
REQ-027 reset mid-HOLD or mid-REQ shall discard queued jobs with no done/tmo/lost pulse; start during reset ignored.

Structure
REQ-028 Shared package holds FSM state encoding (IDLE=0, REQ=1, HOLD=2, REL=3) and counter-width constants derived from parameters.
REQ-029 One sub-module arb_client_ch implements a single channel; arb_client_bank instantiates it three times.

Verification (bench includes a behavioural 3-way priority arbiter, r[1]>r[2]>r[3], grant held while request held, registered grant)
REQ-030 Default params, single start[1] -> r[1] rises next cycle, g[1] one cycle later, busy[1] high 4 cycles, done[1] once, r[1] low one cycle, pend=0.
REQ-031 start[1..3] same cycle -> grants in order 1,2,3, each busy 4 cycles, three done pulses, no tmo.
REQ-032 Channel 1 restarted continuously, TIMEOUT_CYC=4 -> channel 3 pulses tmo[3] after 4 REQ cycles, pend[3] decrements, r[3] low one cycle.
REQ-033 Four start[2] pulses while idle, MAX_PEND=3 -> ovf[2] once, exactly three done[2] pulses.
REQ-034 Force g[1]=0 mid-HOLD -> lost[1] pulse, REL one cycle, re-request, job later completes with done[1].
REQ-035 reset asserted mid-HOLD with pend=2 -> next cycle all outputs 0, no pulses, no further requests.

Source files
------------

// File: rtl/arb_client_bank_pkg.sv
// Shared definitions for the arbiter client bank: channel state encoding
// and counter widths sized for the full legal parameter ranges.
package arb_client_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_REL  = 2'd3
  } ch_state_t;

  // HOLD_CYC and TIMEOUT_CYC are at most 255, so both counters fit in 8 bits.
  localparam int CNT_W  = $clog2(255 + 1);
  // MAX_PEND is at most 7.
  localparam int PEND_W = $clog2(7 + 1);

  // Terminal/load value for a counter that must span 'cyc' cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/arb_client_ch.sv
// One arbiter client channel: job queue counter plus IDLE/REQ/HOLD/REL FSM.
//
// Request/grant handshake: r is held high from REQ through HOLD; the arbiter
// answers with a registered grant g that stays high while r stays high. A
// grant is only acted on in REQ (start of hold) and HOLD (continuation);
// a grant seen in IDLE or REL is ignored. Dropping r for the one REL cycle
// lets the arbiter fall back to idle before the next job requests again.
module arb_client_ch
  import arb_client_bank_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned MAX_PEND    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              g,
  output logic              r,
  output logic              busy,
  output logic              done,
  output logic              tmo,
  output logic              ovf,
  output logic              lost,
  output ch_state_t         state,
  output logic [PEND_W-1:0] pend
);

  localparam logic [CNT_W-1:0]  HOLD_LOAD = cnt_load(HOLD_CYC);
  localparam logic [CNT_W-1:0]  WAIT_LAST = cnt_load(TIMEOUT_CYC);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

  ch_state_t         state_q, state_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [PEND_W-1:0] pend_q;
  logic              done_q, tmo_q, lost_q, ovf_q;
  logic              fin_done, fin_tmo, fin_lost;
  logic              dec, inc, reject;

  // Next-state and counter updates for the channel FSM.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    fin_done = 1'b0;
    fin_tmo  = 1'b0;
    fin_lost = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) begin
          state_d = ST_REQ;
          wait_d  = '0;
        end
      end
      ST_REQ: begin
        if (g) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_REL;
          fin_tmo = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_HOLD: begin
        // A withdrawn grant wins over completion; the job stays queued.
        if (!g) begin
          state_d  = ST_REL;
          fin_lost = 1'b1;
        end else if (hold_q == '0) begin
          state_d  = ST_REL;
          fin_done = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue bookkeeping: a same-cycle finish makes room for a start at the limit.
  always_comb begin
    dec    = fin_done | fin_tmo;
    inc    = start && ((pend_q != PEND_MAX) || dec);
    reject = start && (pend_q == PEND_MAX) && !dec;
  end

  // State, counters, queue depth and registered event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      wait_q  <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      lost_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      if (inc && !dec)      pend_q <= pend_q + 1'b1;
      else if (dec && !inc) pend_q <= pend_q - 1'b1;
      done_q  <= fin_done;
      tmo_q   <= fin_tmo;
      lost_q  <= fin_lost;
      ovf_q   <= reject;
    end
  end

  assign r     = (state_q == ST_REQ) || (state_q == ST_HOLD);
  assign busy  = (state_q == ST_HOLD);
  assign done  = done_q;
  assign tmo   = tmo_q;
  assign lost  = lost_q;
  assign ovf   = ovf_q;
  assign state = state_q;
  assign pend  = pend_q;

endmodule

// File: rtl/arb_client_bank.sv
// Bank of three independent arbiter client channels, indexed 1..3.
module arb_client_bank
  import arb_client_bank_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned MAX_PEND    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:1]             start,
  input  logic [3:1]             g,
  output logic [3:1]             r,
  output logic [3:1]             busy,
  output logic [3:1]             done,
  output logic [3:1]             tmo,
  output logic [3:1]             ovf,
  output logic [3:1]             lost,
  output ch_state_t [3:1]        state_dbg,
  output logic [3:1][PEND_W-1:0] pend_dbg
);

  for (genvar n = 1; n <= 3; n++) begin : g_ch
    arb_client_ch #(
      .HOLD_CYC    (HOLD_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .MAX_PEND    (MAX_PEND)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .start (start[n]),
      .g     (g[n]),
      .r     (r[n]),
      .busy  (busy[n]),
      .done  (done[n]),
      .tmo   (tmo[n]),
      .ovf   (ovf[n]),
      .lost  (lost[n]),
      .state (state_dbg[n]),
      .pend  (pend_dbg[n])
    );
  end

endmodule

// File: tb/tb_arb_client_bank.sv
// Directed bench for arb_client_bank with a registered 3-way priority arbiter.
module tb_arb_client_bank;
  import arb_client_bank_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT with default parameters ----------------
  logic [3:1]             start, g, r, busy, done, tmo, ovf, lost;
  logic [3:1]             arb_g, kill;
  ch_state_t [3:1]        state_dbg;
  logic [3:1][PEND_W-1:0] pend_dbg;

  arb_client_bank dut (
    .clk(clk), .reset(reset), .start(start), .g(g), .r(r), .busy(busy),
    .done(done), .tmo(tmo), .ovf(ovf), .lost(lost),
    .state_dbg(state_dbg), .pend_dbg(pend_dbg)
  );

  // ---------------- DUT with short timeout ----------------
  logic [3:1]             start4, g4, r4, busy4, done4, tmo4, ovf4, lost4;
  ch_state_t [3:1]        state4;
  logic [3:1][PEND_W-1:0] pend4;

  arb_client_bank #(.HOLD_CYC(4), .TIMEOUT_CYC(4), .MAX_PEND(3)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .g(g4), .r(r4), .busy(busy4),
    .done(done4), .tmo(tmo4), .ovf(ovf4), .lost(lost4),
    .state_dbg(state4), .pend_dbg(pend4)
  );

  // Priority arbiters r[1]>r[2]>r[3]; grant kept while its request stays high.
  always_ff @(posedge clk) begin
    if (reset)            arb_g <= '0;
    else if (|(arb_g & r)) arb_g <= arb_g;
    else if (r[1])        arb_g <= 3'b001;
    else if (r[2])        arb_g <= 3'b010;
    else if (r[3])        arb_g <= 3'b100;
    else                  arb_g <= '0;
  end
  assign g = arb_g & ~kill;

  always_ff @(posedge clk) begin
    if (reset)              g4 <= '0;
    else if (|(g4 & r4))    g4 <= g4;
    else if (r4[1])         g4 <= 3'b001;
    else if (r4[2])         g4 <= 3'b010;
    else if (r4[3])         g4 <= 3'b100;
    else                    g4 <= '0;
  end

  // ---------------- event monitor ----------------
  logic clr;
  int   done_cnt[1:3], tmo_cnt[1:3], ovf_cnt[1:3], lost_cnt[1:3];
  int   busy_cnt[1:3], rise_t[1:3];
  int   r_cyc, cyc;
  logic [3:1] busy_prev;

  always @(negedge clk) begin
    if (clr) begin
      for (int n = 1; n <= 3; n++) begin
        done_cnt[n] <= 0; tmo_cnt[n] <= 0; ovf_cnt[n] <= 0;
        lost_cnt[n] <= 0; busy_cnt[n] <= 0; rise_t[n] <= 0;
      end
      r_cyc     <= 0;
      cyc       <= 0;
      busy_prev <= '0;
    end else begin
      cyc       <= cyc + 1;
      busy_prev <= busy;
      if (|r) r_cyc <= r_cyc + 1;
      for (int n = 1; n <= 3; n++) begin
        if (done[n]) done_cnt[n] <= done_cnt[n] + 1;
        if (tmo[n])  tmo_cnt[n]  <= tmo_cnt[n] + 1;
        if (ovf[n])  ovf_cnt[n]  <= ovf_cnt[n] + 1;
        if (lost[n]) lost_cnt[n] <= lost_cnt[n] + 1;
        if (busy[n]) busy_cnt[n] <= busy_cnt[n] + 1;
        if (busy[n] && !busy_prev[n]) rise_t[n] <= cyc;
      end
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_busy(input int n, input string tag);
    int k = 0;
    while (!busy[n] && k < 40) begin
      tick();
      k++;
    end
    check(tag, 32'(busy[n]), 1);
  endtask

  task automatic wait_done(input int n, input int want, input string tag);
    int k = 0;
    while (done_cnt[n] < want && k < 120) begin
      tick();
      k++;
    end
    check(tag, done_cnt[n], want);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset  = 1'b1;
    start  = '0;
    start4 = '0;
    kill   = '0;
    clr    = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_r",     32'(r), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_pulse", 32'({done, tmo, ovf, lost}), 0);
    check("rst_pend",  32'(pend_dbg), 0);
    check("rst_state", 32'(state_dbg), 0);
    reset = 1'b0;
    clr   = 1'b0;
    tick();

    // Single job on channel 1
    start = 3'b001;
    tick();
    start = '0;
    check("s1_pend1", 32'(pend_dbg[1]), 1);
    check("s1_r_idle", 32'(r[1]), 0);
    tick();
    check("s1_r_req", 32'(r[1]), 1);
    check("s1_state_req", 32'(state_dbg[1]), 32'(ST_REQ));
    check("s1_g_low", 32'(g[1]), 0);
    tick();
    check("s1_g_high", 32'(g[1]), 1);
    check("s1_busy_pre", 32'(busy[1]), 0);
    tick();
    check("s1_busy_on", 32'(busy[1]), 1);
    repeat (3) tick();
    check("s1_busy_last", 32'(busy[1]), 1);
    check("s1_done_early", 32'(done[1]), 0);
    tick();
    check("s1_done", 32'(done[1]), 1);
    check("s1_busy_off", 32'(busy[1]), 0);
    check("s1_r_rel", 32'(r[1]), 0);
    check("s1_state_rel", 32'(state_dbg[1]), 32'(ST_REL));
    check("s1_pend0", 32'(pend_dbg[1]), 0);
    tick();
    check("s1_done_off", 32'(done[1]), 0);
    check("s1_state_idle", 32'(state_dbg[1]), 32'(ST_IDLE));
    check("s1_busy_cnt", busy_cnt[1], 4);
    check("s1_done_cnt", done_cnt[1], 1);

    // All three clients at once: served 1, 2, 3 with no timeouts
    clear_counts();
    start = 3'b111;
    tick();
    start = '0;
    wait_done(3, 1, "all_wait_done3");
    repeat (3) tick();
    for (int n = 1; n <= 3; n++) begin
      check($sformatf("all_done_cnt%0d", n), done_cnt[n], 1);
      check($sformatf("all_busy_cnt%0d", n), busy_cnt[n], 4);
      check($sformatf("all_tmo_cnt%0d", n), tmo_cnt[n], 0);
    end
    check("all_order12", 32'(rise_t[1] < rise_t[2]), 1);
    check("all_order23", 32'(rise_t[2] < rise_t[3]), 1);
    check("all_pend", 32'(pend_dbg), 0);

    // Queue overflow on channel 2
    clear_counts();
    start = 3'b010;
    repeat (4) tick();
    start = '0;
    check("ovf_pulse", 32'(ovf[2]), 1);
    check("ovf_pend_full", 32'(pend_dbg[2]), 3);
    tick();
    check("ovf_pulse_off", 32'(ovf[2]), 0);
    wait_done(2, 3, "ovf_wait_done3");
    repeat (10) tick();
    check("ovf_cnt", ovf_cnt[2], 1);
    check("ovf_done_cnt", done_cnt[2], 3);
    check("ovf_pend0", 32'(pend_dbg[2]), 0);

    // Timeout on channel 3 while channel 1 keeps the bus (TIMEOUT_CYC=4)
    start4 = 3'b101;
    tick();
    start4 = 3'b001;
    tick();
    tick();
    start4 = '0;
    tick();
    tick();
    check("tmo_r3_req", 32'(r4[3]), 1);
    check("tmo_not_yet", 32'(tmo4[3]), 0);
    tick();
    check("tmo_pulse", 32'(tmo4[3]), 1);
    check("tmo_r3_rel", 32'(r4[3]), 0);
    check("tmo_pend3", 32'(pend4[3]), 0);
    check("tmo_ch1_busy", 32'(busy4[1]), 1);
    tick();
    check("tmo_pulse_off", 32'(tmo4[3]), 0);
    check("tmo_state_idle", 32'(state4[3]), 32'(ST_IDLE));
    check("tmo_no_done3", 32'(done4[3]), 0);

    // Grant withdrawn mid-hold on channel 1
    clear_counts();
    start = 3'b001;
    tick();
    start = '0;
    wait_busy(1, "lost_wait_busy");
    tick();
    kill = 3'b001;
    tick();
    kill = '0;
    check("lost_pulse", 32'(lost[1]), 1);
    check("lost_no_done", 32'(done[1]), 0);
    check("lost_r_rel", 32'(r[1]), 0);
    check("lost_pend_kept", 32'(pend_dbg[1]), 1);
    tick();
    check("lost_pulse_off", 32'(lost[1]), 0);
    check("lost_state_idle", 32'(state_dbg[1]), 32'(ST_IDLE));
    wait_done(1, 1, "lost_wait_done");
    repeat (3) tick();
    check("lost_cnt", lost_cnt[1], 1);
    check("lost_busy_cnt", busy_cnt[1], 6);
    check("lost_pend0", 32'(pend_dbg[1]), 0);

    // Reset mid-hold with two jobs queued
    start = 3'b001;
    tick();
    tick();
    start = '0;
    wait_busy(1, "rst_wait_busy");
    tick();
    check("rst_pend2", 32'(pend_dbg[1]), 2);
    reset = 1'b1;
    start = 3'b111;
    tick();
    reset = 1'b0;
    start = '0;
    check("mid_rst_r", 32'(r), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pulse", 32'({done, tmo, ovf, lost}), 0);
    check("mid_rst_pend", 32'(pend_dbg), 0);
    check("mid_rst_state", 32'(state_dbg), 0);
    clear_counts();
    repeat (20) tick();
    check("post_rst_r_cyc", r_cyc, 0);
    check("post_rst_pulses",
          done_cnt[1] + tmo_cnt[1] + ovf_cnt[1] + lost_cnt[1] +
          done_cnt[2] + tmo_cnt[2] + ovf_cnt[2] + lost_cnt[2] +
          done_cnt[3] + tmo_cnt[3] + ovf_cnt[3] + lost_cnt[3], 0);
    check("post_rst_busy", busy_cnt[1] + busy_cnt[2] + busy_cnt[3], 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
